eth_frame_builder: RTL and testbench

//  Downstream of the sample-FIFO read controller. Consumes FIFO read data

---
 rtl/eth_frame_pkg.sv | 9 +
 rtl/eth_frame_builder_delay.sv | 26 ++
 rtl/eth_frame_builder.sv | 111 +++++++++++
 tb/tb_eth_frame_builder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/eth_frame_pkg.sv
// eth_frame_pkg: shared FSM encoding and frame layout constants for eth_frame_builder
package eth_frame_pkg;
  localparam logic [1:0] S_IDLE = 2'd0, S_HDR = 2'd1, S_PAY = 2'd2, S_TRL = 2'd3;
  typedef enum logic [1:0] {IDLE = S_IDLE, HDR = S_HDR, PAY = S_PAY, TRL = S_TRL} frame_state_t;
  localparam int HDR_WORDS = 4;
  localparam int TRL_WORDS = 2;
  localparam int HDR_MAGIC = 0, HDR_SEQ = 1, HDR_CHAN = 2, HDR_MAX = 3;
  localparam int TRL_COUNT = 0, TRL_SUM = 1;
endpackage

// File: rtl/eth_frame_builder_delay.sv
// word_delay_line: DEPTH-stage valid+data shift register with async clear
module word_delay_line #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v    <= (v << 1) | DEPTH'(in_valid);
      d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
    end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/eth_frame_builder.sv
// eth_frame_builder: frames eth_en-qualified FIFO bursts into header/payload/trailer packets
module eth_frame_builder
  import eth_frame_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                RD_LAT      = 1,
  parameter int                MAX_PAYLOAD = 1024,
  parameter logic [DATA_W-1:0] MAGIC       = 16'hADC0,
  parameter logic [DATA_W-1:0] CHAN_ID     = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              eth_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic [15:0]       drop_cnt,
  output logic              err
);
  localparam logic [DATA_W-1:0] MAXW = DATA_W'(MAX_PAYLOAD);
  logic [RD_LAT-1:0] en_pipe;
  logic              wv, wv_q, cap, accept, drop, take, dl_valid;
  logic [DATA_W-1:0] dl_data, n, sum, seq, nxt_data;
  logic [1:0]        cnt, nxt_cnt;
  logic              nxt_valid, nxt_sof, nxt_eof;
  frame_state_t      state, nxt_state;
  assign wv     = en_pipe[RD_LAT-1];
  assign accept = wv & ~wv_q & (state == IDLE);
  assign drop   = wv & ~wv_q & (state != IDLE);
  assign take   = accept | (cap & wv & (n < MAXW));
  // payload lags by the header length so it lands right after header word3
  word_delay_line #(.W(DATA_W), .DEPTH(HDR_WORDS)) u_dly (
    .clk(clk), .rstn(rstn), .in_valid(take), .in_data(din),
    .out_valid(dl_valid), .out_data(dl_data)
  );
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_valid = 1'b0;
    nxt_sof   = 1'b0;
    nxt_eof   = 1'b0;
    nxt_data  = '0;
    case (state)
      IDLE: if (accept) begin
        nxt_state = HDR;
        nxt_cnt   = 2'(HDR_SEQ);
        nxt_valid = 1'b1;
        nxt_sof   = 1'b1;
        nxt_data  = MAGIC;
      end
      HDR: begin
        nxt_valid = 1'b1;
        nxt_data  = (cnt == 2'(HDR_SEQ)) ? seq : (cnt == 2'(HDR_CHAN)) ? CHAN_ID : MAXW;
        nxt_cnt   = cnt + 2'd1;
        nxt_state = (cnt == 2'(HDR_MAX)) ? PAY : HDR;
      end
      PAY: begin
        nxt_valid = 1'b1;
        nxt_data  = dl_valid ? dl_data : n;
        nxt_cnt   = 2'(TRL_SUM);
        nxt_state = dl_valid ? PAY : TRL;
      end
      TRL: begin
        nxt_valid = 1'b1;
        nxt_eof   = 1'b1;
        nxt_data  = sum;
        nxt_state = (cnt == 2'(TRL_WORDS - 1)) ? IDLE : TRL;
      end
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      en_pipe  <= '0;
      wv_q     <= 1'b0;
      cap      <= 1'b0;
      n        <= '0;
      sum      <= '0;
      seq      <= '0;
      cnt      <= '0;
      state    <= IDLE;
      drop_cnt <= '0;
      err      <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
    end else begin
      en_pipe <= (en_pipe << 1) | RD_LAT'(eth_en);
      wv_q    <= wv;
      cap     <= accept | (cap & wv);
      if (accept) begin
        n   <= DATA_W'(1);
        sum <= din;
      end else if (take) begin
        n   <= n + 1'b1;
        sum <= sum + din;
      end
      if (drop | (cap & wv & ~take)) err <= 1'b1;
      if (drop & ~&drop_cnt) drop_cnt <= drop_cnt + 16'd1;
      if (state == TRL) seq <= seq + 1'b1;
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      tx_data  <= nxt_data;
      tx_valid <= nxt_valid;
      tx_sof   <= nxt_sof;
      tx_eof   <= nxt_eof;
    end
endmodule

// File: tb/tb_eth_frame_builder.sv
// tb_eth_frame_builder: bursts into a full-size and an 8-word-cap builder, checked against a frame-level model
module tb_eth_frame_builder;
  logic        clk = 1'b0, rstn = 1'b1, eth_en = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] tx_data [2];
  logic [15:0] drop_cnt [2];
  logic        tx_valid [2], tx_sof [2], tx_eof [2], err [2];
  eth_frame_builder dut0 (
    .clk(clk), .rstn(rstn), .eth_en(eth_en), .din(din),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_sof(tx_sof[0]), .tx_eof(tx_eof[0]),
    .drop_cnt(drop_cnt[0]), .err(err[0])
  );
  eth_frame_builder #(.MAX_PAYLOAD(8)) dut1 (
    .clk(clk), .rstn(rstn), .eth_en(eth_en), .din(din),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_sof(tx_sof[1]), .tx_eof(tx_eof[1]),
    .drop_cnt(drop_cnt[1]), .err(err[1])
  );
  always #5 clk = ~clk;
  int          n_chk, n_err, cyc, last, b1_eof, b2_eof;
  bit          wv_plan [int];
  logic [15:0] din_plan [int];
  logic [18:0] exp_w [int];
  int          idle_from [2], drop_m [2];
  logic [15:0] seq_m [2];
  bit          err_m [2];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic int max_of(input int i);
    return i ? 8 : 1024;
  endfunction
  task automatic put(input int i, input int c, input logic [18:0] w);
    exp_w[i * 1000000 + c] = w;
  endtask
  // frame-level rules: accept only when the previous frame has fully left, else drop
  task automatic add_burst(input int t, input logic [15:0] w[$]);
    int n, m;
    logic [15:0] s;
    for (int k = 0; k < w.size(); k++) begin
      wv_plan[t + k]  = 1'b1;
      din_plan[t + k] = w[k];
    end
    for (int i = 0; i < 2; i++) begin
      m = max_of(i);
      if (t >= idle_from[i]) begin
        n = (w.size() < m) ? w.size() : m;
        s = '0;
        put(i, t + 1, {3'b110, 16'hADC0});
        put(i, t + 2, {3'b100, seq_m[i]});
        put(i, t + 3, {3'b100, 16'h0000});
        put(i, t + 4, {3'b100, 16'(m)});
        for (int k = 0; k < n; k++) begin
          put(i, t + 5 + k, {3'b100, w[k]});
          s += w[k];
        end
        put(i, t + 5 + n, {3'b100, 16'(n)});
        put(i, t + 6 + n, {3'b101, s});
        idle_from[i] = t + 6 + n;
        seq_m[i]++;
        if (w.size() > m) err_m[i] = 1'b1;
      end else begin
        if (drop_m[i] < 65535) drop_m[i]++;
        err_m[i] = 1'b1;
      end
    end
  endtask
  task automatic burst_after(input int gap, input logic [15:0] w[$]);
    add_burst(last + gap, w);
    last = last + gap + w.size() - 1;
  endtask
  task automatic step();
    int k;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      k = i * 1000000 + cyc;
      chk($sformatf("tx%0d@%0d", i, cyc), {45'd0, tx_valid[i], tx_sof[i], tx_eof[i], tx_data[i]},
          {45'd0, exp_w.exists(k) ? exp_w[k] : 19'd0});
    end
    if (cyc == b1_eof) chk("b1_csum", {47'd0, tx_eof[0], tx_data[0]}, {47'd0, 1'b1, 16'hFE00});
    if (cyc == b2_eof) chk("b2_csum", {47'd0, tx_eof[0], tx_data[0]}, {47'd0, 1'b1, 16'h0002});
    eth_en = wv_plan.exists(cyc + 1);
    din    = din_plan.exists(cyc) ? din_plan[cyc] : 16'($urandom);
  endtask
  task automatic check_status(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_status%0d", tag, i), {47'd0, err[i], drop_cnt[i]}, {47'd0, err_m[i], 16'(drop_m[i])});
  endtask
  task automatic model_reset();
    wv_plan.delete();
    din_plan.delete();
    exp_w.delete();
    for (int i = 0; i < 2; i++) begin
      idle_from[i] = 0;
      drop_m[i]    = 0;
      seq_m[i]     = '0;
      err_m[i]     = 1'b0;
    end
  endtask
  initial begin
    logic [15:0] q[$];
    int stop;
    model_reset();
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset%0d", i), {28'd0, tx_valid[i], tx_sof[i], tx_eof[i], tx_data[i], drop_cnt[i], err[i]}, 64'd0);
    q = {};
    for (int k = 0; k < 1024; k++) q.push_back(16'(k));
    add_burst(20, q);
    last   = 20 + 1024 - 1;
    b1_eof = 20 + 6 + 1024;
    b2_eof = last + 8 + 6 + 3;
    burst_after(8, '{16'h0001, 16'h0002, 16'hFFFF});
    q = {};
    for (int k = 0; k < 8; k++) q.push_back(16'($urandom));
    burst_after(8, q);
    burst_after(4, q);
    burst_after(8, q);
    burst_after(6, q);
    for (int b = 0; b < 30; b++) begin
      q = {};
      for (int k = 0; k < $urandom_range(1, 12); k++) q.push_back(16'($urandom));
      burst_after($urandom_range(2, 14), q);
    end
    stop = last + 30;
    while (cyc < stop) begin
      step();
      if (cyc == 3) rstn = 1'b1;
    end
    check_status("phase1");
    q = {};
    for (int k = 0; k < 1024; k++) q.push_back(16'(k));
    add_burst(cyc + 5, q);
    stop = cyc + 5 + 5 + 500;
    while (cyc < stop) step();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("midreset%0d", i), {47'd0, tx_valid[i], drop_cnt[i]}, 64'd0);
    model_reset();
    eth_en = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    force dut0.seq = 16'hFFFF;
    step();
    release dut0.seq;
    seq_m[0] = 16'hFFFF;
    last = cyc;
    for (int b = 0; b < 2; b++) begin
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(16'($urandom));
      burst_after(9, q);
    end
    stop = last + 20;
    while (cyc < stop) step();
    check_status("phase2");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
